// File: rtl/apb_rgu_requester.sv
// APB3 requester for the RGU register slave.
// Turns one valid/ready command into one APB transfer (SETUP then ACCESS),
// waits for PREADY under a watchdog, and returns read data and error status
// on a valid/ready response channel. Misaligned addresses are rejected locally.
module apb_rgu_requester #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                psel_next, penable_next, pwrite_next;
  logic [ADDR_W-1:0]   paddr_next;
  logic [DATA_W-1:0]   pwdata_next;
  logic                rsp_valid_next, rsp_err_next, rsp_timeout_next;
  logic [DATA_W-1:0]   rsp_rdata_next;
  logic                timeout_hit;

  // Terminal count of the ACCESS-phase watchdog; tied off when disabled.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end else begin : g_wdog
      assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  // Commands are only taken while nothing is in flight.
  assign cmd_ready = (state_reg == IDLE);

  // State, watchdog and all registered outputs; reset clears everything.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      PSEL        <= psel_next;
      PENABLE     <= penable_next;
      PWRITE      <= pwrite_next;
      PADDR       <= paddr_next;
      PWDATA      <= pwdata_next;
      rsp_valid   <= rsp_valid_next;
      rsp_err     <= rsp_err_next;
      rsp_timeout <= rsp_timeout_next;
      rsp_rdata   <= rsp_rdata_next;
    end
  end

  // Next-state and next-output decode; everything holds unless changed below.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    psel_next        = PSEL;
    penable_next     = PENABLE;
    pwrite_next      = PWRITE;
    paddr_next       = PADDR;
    pwdata_next      = PWDATA;
    rsp_valid_next   = rsp_valid;
    rsp_err_next     = rsp_err;
    rsp_timeout_next = rsp_timeout;
    rsp_rdata_next   = rsp_rdata;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_wdata;
          if (cmd_addr[1:0] != 2'b00) begin
            // Rejected locally: answer straight away, bus stays idle.
            rsp_valid_next   = 1'b1;
            rsp_err_next     = 1'b1;
            rsp_timeout_next = 1'b0;
            rsp_rdata_next   = '0;
            state_next       = RESP;
          end else begin
            psel_next  = 1'b1;
            cnt_next   = '0;
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        cnt_next = cnt_reg + 1'b1;
        // PREADY is checked first so it wins over a coincident timeout.
        if (PREADY) begin
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = PSLVERR;
          rsp_timeout_next = 1'b0;
          rsp_rdata_next   = PWRITE ? '0 : PRDATA;
          state_next       = RESP;
        end else if (timeout_hit) begin
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_rdata_next   = '0;
          state_next       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_rgu_requester.sv
// Self-checking bench for apb_rgu_requester: directed cases from the test plan
// followed by random commands, each checked against a transaction-level model.
module tb_apb_rgu_requester;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TMO    = 4;
  localparam int CNT_W  = 4;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;

  int n_checks = 0;
  int n_errors = 0;

  // Slave stimulus knobs for the current transfer.
  int                cur_waits = 0;
  logic              cur_slverr = 1'b0;
  logic [DATA_W-1:0] cur_rdata = '0;
  logic              noise_err = 1'b0;
  logic [DATA_W-1:0] noise_data = '0;
  int                acc_cnt = 0;

  always #5 PCLK = ~PCLK;

  apb_rgu_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Slave: answers after cur_waits wait states; drives junk while waiting.
  assign PREADY  = PSEL && PENABLE && (acc_cnt == cur_waits);
  assign PSLVERR = PREADY ? cur_slverr : noise_err;
  assign PRDATA  = PREADY ? cur_rdata : noise_data;

  // Count elapsed ACCESS cycles of the current transfer.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  always @(negedge PCLK) noise_data <= $urandom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end; expectations come from the transaction rules.
  task automatic run_txn(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int waits,
                         input logic slverr, input logic [DATA_W-1:0] rdata,
                         input logic nerr, input int hold);
    logic              mis = (addr[1:0] != 2'b00);
    logic              tmo = !mis && (waits >= TMO);
    int                exp_lat = mis ? 1 : (tmo ? 2 + TMO : 3 + waits);
    int                exp_pen = mis ? 0 : (tmo ? TMO : waits + 1);
    logic              exp_err = mis || tmo || slverr;
    logic [DATA_W-1:0] exp_rd  = (mis || tmo || wr) ? '0 : rdata;
    int k = 0, psel_n = 0, pen_n = 0, first_psel = -1;
    logic [DATA_W-1:0] held;

    cur_waits = waits; cur_slverr = slverr; cur_rdata = rdata; noise_err = nerr;
    @(negedge PCLK);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; rsp_ready = 0;
    @(posedge PCLK);
    while (!rsp_valid && k < 60) begin
      @(negedge PCLK);
      k++;
      cmd_valid = 0;
      if (PSEL) begin
        psel_n++;
        if (first_psel < 0) first_psel = k;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata)
          chk("bus_hold", {PWRITE, PADDR, PWDATA}, {wr, addr, wdata});
      end
      if (PENABLE) pen_n++;
      if (!rsp_valid) chk("cmd_ready_busy", cmd_ready, 0);
    end
    chk("rsp_latency", k, exp_lat);
    chk("psel_cycles", psel_n, mis ? 0 : exp_pen + 1);
    if (!mis) chk("psel_first", first_psel, 1);
    chk("penable_cycles", pen_n, exp_pen);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_timeout", rsp_timeout, tmo);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("bus_idle_resp", {PSEL, PENABLE}, 0);
    held = rsp_rdata;
    for (int d = 0; d < hold; d++) begin
      @(negedge PCLK);
      chk("rsp_hold", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b1, exp_err, tmo, held});
      chk("cmd_ready_resp", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge PCLK);
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    $display("txn %0d: %s addr=%03h waits=%0d lat=%0d err=%0b tmo=%0b rdata=%08h",
             id, wr ? "WR" : "RD", addr, waits, k, rsp_err, rsp_timeout, rsp_rdata);
  endtask

  initial begin
    PRESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, PWRITE}, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_rdata", rsp_rdata, 0);
    PRESETn = 1;

    // Directed cases.
    run_txn(0, 1, 12'h014, 32'h0000_0001, 0, 0, 32'h0, 0, 0);
    run_txn(1, 0, 12'h008, 32'h0,         3, 0, 32'hDEAD_BEEF, 0, 0);
    run_txn(2, 0, 12'h0FC, 32'h0,         2, 1, 32'h1234_5678, 1, 1);
    run_txn(3, 0, 12'h100, 32'h0,         TMO - 1, 0, 32'hA5A5_0001, 0, 0);
    run_txn(4, 1, 12'h020, 32'hCAFE_0000, 50, 0, 32'h0, 0, 0);
    run_txn(5, 0, 12'h024, 32'h0,         1, 0, 32'h0BAD_F00D, 0, 0);
    run_txn(6, 0, 12'h006, 32'h0,         0, 0, 32'h0, 0, 5);

    // Reset in the middle of ACCESS.
    cur_waits = 50;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h030;
    @(negedge PCLK);
    cmd_valid = 0;
    @(negedge PCLK);
    chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 0;
    #1 chk("async_reset", {PSEL, PENABLE, rsp_valid}, 0);
    @(negedge PCLK);
    PRESETn = 1;
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("no_stale_rsp", {rsp_valid, PSEL}, 0);
    end
    chk("cmd_ready_after_reset", cmd_ready, 1);
    rsp_ready = 0;
    $display("txn 7: reset during ACCESS");

    // Random commands.
    for (int t = 8; t < 48; t++) begin
      logic [ADDR_W-1:0] a = ADDR_W'($urandom_range(0, 1023) * 4);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_txn(t, 1'($urandom), a, $urandom, $urandom_range(0, TMO + 1),
              1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
